wb_sdio_csr_slave: RTL and testbench

//  Parametrised Wishbone B4 classic slave holding the SDIO controller CSR bank.

---
 rtl/sdio_csr_pkg.sv | 34 +++
 rtl/neg_edge_detector.sv | 18 +
 rtl/wb_sdio_csr_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_sdio_csr_slave.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sdio_csr_pkg.sv
// rtl/sdio_csr_pkg.sv - SDIO CSR bank offsets, status/control bit indices and slave FSM encodings
package sdio_csr_pkg;

  localparam int OFF_POWER   = 'h00;
  localparam int OFF_CLKCR   = 'h04;
  localparam int OFF_ARG     = 'h08;
  localparam int OFF_CMD     = 'h0C;
  localparam int OFF_EXT_LO  = 'h10;
  localparam int OFF_EXT_HI  = 'h20;
  localparam int OFF_DTIMER  = 'h24;
  localparam int OFF_DLEN    = 'h28;
  localparam int OFF_DCTRL   = 'h2C;
  localparam int OFF_DCOUNT  = 'h30;
  localparam int OFF_STA     = 'h34;
  localparam int OFF_FIFOCNT = 'h38;

  localparam int STA_CMDACT = 11;
  localparam int STA_TXACT  = 12;
  localparam int STA_RXACT  = 13;
  localparam int CMD_CPSMEN = 10;
  localparam int DCTRL_DTEN = 0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOCAL    = 3'd1;
  localparam logic [2:0] ST_EXT_WAIT = 3'd2;
  localparam logic [2:0] ST_BURST    = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  typedef enum logic [1:0] {RESP_ACK, RESP_ERR, RESP_RTY, RESP_EXT} resp_e;

endpackage

// File: rtl/neg_edge_detector.sv
// rtl/neg_edge_detector.sv - one-cycle pulse on a 1->0 transition of a level input
module neg_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign fall = d_q & ~d;

endmodule

// File: rtl/wb_sdio_csr_slave.sv
// rtl/wb_sdio_csr_slave.sv - Wishbone B4 classic/burst slave for the SDIO CPSM/DPSM CSR bank
module wb_sdio_csr_slave
  import sdio_csr_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 8,
  parameter  int DATA_WIDTH  = 32,
  parameter  int EXT_TIMEOUT = 16,
  parameter  int BURST_EN    = 1,
  localparam int SEL_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o,
  input  logic [DATA_WIDTH-1:0] sd_status,
  input  logic [DATA_WIDTH-1:0] sd_dcount,
  input  logic [DATA_WIDTH-1:0] sd_fifocnt,
  output logic [DATA_WIDTH-1:0] sd_pwr,
  output logic [DATA_WIDTH-1:0] sd_clkcr,
  output logic [DATA_WIDTH-1:0] sd_arg,
  output logic [DATA_WIDTH-1:0] sd_cmd,
  output logic [DATA_WIDTH-1:0] sd_dtimer,
  output logic [DATA_WIDTH-1:0] sd_dlen,
  output logic [DATA_WIDTH-1:0] sd_dctrl,
  output logic [ADDR_WIDTH-1:0] ext_adr_o,
  output logic                  ext_rd_o,
  input  logic                  ext_ack_i,
  input  logic [DATA_WIDTH-1:0] ext_dat_i
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam int TW = $clog2(EXT_TIMEOUT + 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [2:0]            cti_q;
  logic [1:0]            bte_q;
  logic                  ack_q, err_q, rty_q;
  logic [TW-1:0]         timer;
  logic [WW-1:0]         tgt_w;
  int                    tgt_off, wr_off;
  resp_e                 dec;
  logic                  busy, burst_ok, bad_burst, wr_en, cmd_fall, data_fall;
  logic [DATA_WIDTH-1:0] rd_data, cmd_base, dctrl_base;

  function automatic int word_off(input logic [WW-1:0] w);
    return int'(w) << 2;
  endfunction

  function automatic resp_e decode(input int off, input logic f_we, input logic f_busy);
    case (off)
      OFF_POWER, OFF_CLKCR:                             decode = RESP_ACK;
      OFF_ARG, OFF_CMD, OFF_DTIMER, OFF_DLEN, OFF_DCTRL: decode = (f_we && f_busy) ? RESP_RTY : RESP_ACK;
      OFF_DCOUNT, OFF_STA, OFF_FIFOCNT:                 decode = f_we ? RESP_ERR : RESP_ACK;
      default: begin
        if (off >= OFF_EXT_LO && off <= OFF_EXT_HI) decode = f_we ? RESP_ERR : RESP_EXT;
        else                                        decode = RESP_ERR;
      end
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] upd(input logic [DATA_WIDTH-1:0] old_v, input logic hit);
    upd = old_v;
    for (int i = 0; i < SEL_WIDTH; i++)
      if (hit && sel_i[i]) upd[8*i +: 8] = dat_i[8*i +: 8];
  endfunction

  // In a burst the response for the next beat is prepared while the current beat is acked.
  assign tgt_w     = (state == ST_BURST) ? addr_q[ADDR_WIDTH-1:2] + WW'(1) : addr_q[ADDR_WIDTH-1:2];
  assign tgt_off   = word_off(tgt_w);
  assign wr_off    = word_off(addr_q[ADDR_WIDTH-1:2]);
  assign busy      = sd_status[STA_CMDACT] | sd_status[STA_TXACT] | sd_status[STA_RXACT];
  assign dec       = decode(tgt_off, we_q, busy);
  assign burst_ok  = (BURST_EN != 0) && (cti_q == CTI_INCR);
  assign bad_burst = burst_ok && (bte_q != BTE_LINEAR);
  // Write data is latched on the edge that completes the acked beat.
  assign wr_en     = ack_q && cyc_i && stb_i && we_q && (state == ST_RESP || state == ST_BURST);

  assign ack_o = ack_q & cyc_i & stb_i;
  assign err_o = err_q & cyc_i & stb_i;
  assign rty_o = rty_q & cyc_i & stb_i;

  always_comb begin
    case (tgt_off)
      OFF_POWER:   rd_data = sd_pwr;
      OFF_CLKCR:   rd_data = sd_clkcr;
      OFF_ARG:     rd_data = sd_arg;
      OFF_CMD:     rd_data = sd_cmd;
      OFF_DTIMER:  rd_data = sd_dtimer;
      OFF_DLEN:    rd_data = sd_dlen;
      OFF_DCTRL:   rd_data = sd_dctrl;
      OFF_DCOUNT:  rd_data = sd_dcount;
      OFF_STA:     rd_data = sd_status;
      OFF_FIFOCNT: rd_data = sd_fifocnt;
      default:     rd_data = '0;
    endcase
  end

  neg_edge_detector u_cmd_fall  (.clk(clk), .rst(rst), .d(sd_status[STA_CMDACT]), .fall(cmd_fall));
  neg_edge_detector u_data_fall (.clk(clk), .rst(rst), .d(sd_status[STA_TXACT] | sd_status[STA_RXACT]),
                                 .fall(data_fall));

  always_comb begin
    cmd_base   = sd_cmd;
    dctrl_base = sd_dctrl;
    if (cmd_fall)  cmd_base[CMD_CPSMEN]   = 1'b0;
    if (data_fall) dctrl_base[DCTRL_DTEN] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      cti_q     <= '0;
      bte_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      dat_o     <= '0;
      ext_rd_o  <= 1'b0;
      ext_adr_o <= '0;
      timer     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            addr_q <= adr_i;
            we_q   <= we_i;
            cti_q  <= cti_i;
            bte_q  <= bte_i;
            state  <= ST_LOCAL;
          end
        end
        ST_LOCAL, ST_BURST: begin
          if (!cyc_i) begin
            state <= ST_IDLE;
          end else if (state == ST_BURST && (!stb_i || cti_i != CTI_INCR)) begin
            state <= ST_IDLE;
          end else if (state == ST_LOCAL && bad_burst) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            addr_q <= {tgt_w, addr_q[1:0]};
            case (dec)
              RESP_ACK: begin
                ack_q <= 1'b1;
                dat_o <= rd_data;
                state <= burst_ok ? ST_BURST : ST_RESP;
              end
              RESP_EXT: begin
                ext_adr_o <= {tgt_w, addr_q[1:0]};
                ext_rd_o  <= 1'b1;
                timer     <= '0;
                state     <= ST_EXT_WAIT;
              end
              RESP_RTY: begin
                rty_q <= 1'b1;
                state <= ST_RESP;
              end
              default: begin
                err_q <= 1'b1;
                state <= ST_RESP;
              end
            endcase
          end
        end
        ST_EXT_WAIT: begin
          if (!cyc_i) begin
            ext_rd_o <= 1'b0;
            state    <= ST_IDLE;
          end else if (ext_ack_i) begin
            ext_rd_o <= 1'b0;
            dat_o    <= ext_dat_i;
            ack_q    <= 1'b1;
            state    <= ST_RESP;
          end else if (timer == TW'(EXT_TIMEOUT - 1)) begin
            ext_rd_o <= 1'b0;
            err_q    <= 1'b1;
            state    <= ST_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Auto-clear is applied first so that a same-cycle bus write to the same lane wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_pwr    <= '0;
      sd_clkcr  <= '0;
      sd_arg    <= '0;
      sd_cmd    <= '0;
      sd_dtimer <= '0;
      sd_dlen   <= '0;
      sd_dctrl  <= '0;
    end else begin
      sd_pwr    <= upd(sd_pwr,     wr_en && wr_off == OFF_POWER);
      sd_clkcr  <= upd(sd_clkcr,   wr_en && wr_off == OFF_CLKCR);
      sd_arg    <= upd(sd_arg,     wr_en && wr_off == OFF_ARG);
      sd_cmd    <= upd(cmd_base,   wr_en && wr_off == OFF_CMD);
      sd_dtimer <= upd(sd_dtimer,  wr_en && wr_off == OFF_DTIMER);
      sd_dlen   <= upd(sd_dlen,    wr_en && wr_off == OFF_DLEN);
      sd_dctrl  <= upd(dctrl_base, wr_en && wr_off == OFF_DCTRL);
    end
  end

endmodule

// File: tb/tb_wb_sdio_csr_slave.sv
// tb/tb_wb_sdio_csr_slave.sv - directed self-checking bench for wb_sdio_csr_slave
module tb_wb_sdio_csr_slave;

  logic        clk, rst, cyc, stb, we, ext_ack;
  logic [7:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w, status, ext_dat;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o, sd_pwr, sd_clkcr, sd_arg, sd_cmd, sd_dtimer, sd_dlen, sd_dctrl;
  logic        ack_o, err_o, rty_o, ext_rd_o;
  logic [7:0]  ext_adr_o;

  int          total = 0;
  int          bad = 0;
  logic [2:0]  r;
  logic [31:0] q;
  int          n, beats, first, last, rd_cnt;
  logic        acked;
  logic [31:0] bdat [4];

  wb_sdio_csr_slave dut (
    .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel),
    .dat_i(dat_w), .cti_i(cti), .bte_i(bte), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .rty_o(rty_o), .sd_status(status), .sd_dcount(32'h55), .sd_fifocnt(32'h77),
    .sd_pwr(sd_pwr), .sd_clkcr(sd_clkcr), .sd_arg(sd_arg), .sd_cmd(sd_cmd),
    .sd_dtimer(sd_dtimer), .sd_dlen(sd_dlen), .sd_dctrl(sd_dctrl), .ext_adr_o(ext_adr_o),
    .ext_rd_o(ext_rd_o), .ext_ack_i(ext_ack), .ext_dat_i(ext_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // r = {ack, err, rty}; n = edges from start until the response is visible
  task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                         output logic [2:0] rr, output logic [31:0] qq, output int nn);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    nn = 0; rr = 3'b000;
    while (nn < 40 && rr == 3'b000) begin
      tick;
      nn++;
      rr = {ack_o, err_o, rty_o};
    end
    qq = dat_o;
    tick;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_w = 0; cti = 0; bte = 0;
    status = 0; ext_ack = 0; ext_dat = 0;
    repeat (3) tick;
    chk("rst_resp", {ack_o, err_o, rty_o}, 3'b000);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_ext", {ext_rd_o, ext_adr_o}, 9'h0);
    chk("rst_csr", sd_pwr | sd_clkcr | sd_arg | sd_cmd | sd_dtimer | sd_dlen | sd_dctrl, 32'h0);
    rst = 1'b0;
    tick;

    wb_xfer(1, 8'h04, 4'hF, 32'hFFFF_FFFF, r, q, n);
    wb_xfer(1, 8'h04, 4'h3, 32'hA5A5_1234, r, q, n);
    chk("clkcr_wr_resp", r, 3'b100);
    chk("clkcr_wr_latency", n, 2);
    chk("clkcr_lanes", sd_clkcr, 32'hFFFF_1234);
    wb_xfer(0, 8'h04, 4'hF, 0, r, q, n);
    chk("clkcr_rd", q, 32'hFFFF_1234);

    wb_xfer(1, 8'h00, 4'hF, 32'h3, r, q, n);
    wb_xfer(1, 8'h08, 4'hF, 32'h11, r, q, n);
    wb_xfer(1, 8'h0C, 4'hF, 32'h22, r, q, n);
    wb_xfer(1, 8'h00, 4'h0, 32'hDEAD_BEEF, r, q, n);
    chk("sel0_resp", r, 3'b100);
    chk("sel0_keep", sd_pwr, 32'h3);

    cyc = 1; stb = 1; we = 0; adr = 8'h00; cti = 3'b010; bte = 0; sel = 4'hF;
    beats = 0; first = -1; last = -1; n = 0;
    tick;
    while (beats < 4 && n < 20) begin
      acked = ack_o;
      if (acked) begin
        bdat[beats] = dat_o;
        if (beats == 0) first = n;
        last = n;
        beats++;
      end
      tick;
      n++;
      if (acked) begin
        adr = adr + 8'd4;
        cti = (beats == 3) ? 3'b111 : 3'b010;
      end
    end
    cyc = 0; stb = 0; cti = 0;
    chk("burst_beats", beats, 4);
    chk("burst_consecutive", last - first, 3);
    chk("burst_d0", bdat[0], 32'h3);
    chk("burst_d1", bdat[1], 32'hFFFF_1234);
    chk("burst_d2", bdat[2], 32'h11);
    chk("burst_d3", bdat[3], 32'h22);
    tick;
    chk("burst_end_idle", ack_o, 1'b0);

    status = 32'h0000_0800;
    wb_xfer(1, 8'h0C, 4'hF, 32'h99, r, q, n);
    chk("busy_cmd_rty", r, 3'b001);
    chk("busy_cmd_keep", sd_cmd, 32'h22);
    wb_xfer(1, 8'h00, 4'hF, 32'h5, r, q, n);
    chk("busy_pwr_ack", r, 3'b100);
    chk("busy_pwr_val", sd_pwr, 32'h5);
    status = 0;
    tick;

    cyc = 1; stb = 1; we = 0; adr = 8'h14;
    tick;
    tick;
    chk("ext_rd_req", {ext_rd_o, ext_adr_o}, {1'b1, 8'h14});
    tick;
    tick;
    ext_ack = 1; ext_dat = 32'h1234;
    tick;
    ext_ack = 0; ext_dat = 0;
    chk("ext_ack_resp", {ack_o, err_o, rty_o}, 3'b100);
    chk("ext_dat", dat_o, 32'h1234);
    chk("ext_rd_drop", ext_rd_o, 1'b0);
    tick;
    cyc = 0; stb = 0;

    cyc = 1; stb = 1; we = 0; adr = 8'h18;
    n = 0; rd_cnt = 0; r = 0;
    while (n < 60 && r == 3'b000) begin
      tick;
      n++;
      if (ext_rd_o) rd_cnt++;
      r = {ack_o, err_o, rty_o};
    end
    chk("timeout_err", r, 3'b010);
    chk("timeout_rd_cycles", rd_cnt, 16);
    chk("timeout_rd_drop", ext_rd_o, 1'b0);
    tick;
    cyc = 0; stb = 0;

    wb_xfer(1, 8'h3C, 4'hF, 32'h1, r, q, n);
    chk("unmapped_wr_err", r, 3'b010);
    wb_xfer(1, 8'h34, 4'hF, 32'h1, r, q, n);
    chk("ro_wr_err", r, 3'b010);
    wb_xfer(1, 8'h14, 4'hF, 32'h1, r, q, n);
    chk("ext_wr_err", r, 3'b010);
    wb_xfer(0, 8'h30, 4'hF, 0, r, q, n);
    chk("dcount_rd", q, 32'h55);
    cti = 3'b010; bte = 2'b01;
    wb_xfer(0, 8'h00, 4'hF, 0, r, q, n);
    chk("bad_bte_err", r, 3'b010);

    cyc = 1; stb = 1; we = 0; adr = 8'h1C;
    tick;
    tick;
    chk("abort_rd_req", ext_rd_o, 1'b1);
    cyc = 0; stb = 0;
    tick;
    chk("abort_rd_drop", ext_rd_o, 1'b0);
    chk("abort_no_resp", {ack_o, err_o, rty_o}, 3'b000);

    wb_xfer(1, 8'h0C, 4'hF, 32'h400, r, q, n);
    wb_xfer(1, 8'h2C, 4'hF, 32'h1, r, q, n);
    status = 32'h0000_1800;
    tick;
    tick;
    chk("autoclr_pre", {sd_cmd[15:0], sd_dctrl[15:0]}, {16'h0400, 16'h0001});
    status = 0;
    tick;
    chk("autoclr_cmd", sd_cmd, 32'h0);
    chk("autoclr_dctrl", sd_dctrl, 32'h0);

    cyc = 1; stb = 1; we = 0; adr = 8'h00;
    tick;
    rst = 1;
    tick;
    chk("midrst_resp", {ack_o, err_o, rty_o}, 3'b000);
    chk("midrst_csr", sd_pwr | sd_clkcr, 32'h0);
    cyc = 0; stb = 0; rst = 0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
